// File: rtl/mbed_tx_framer.sv
// Buffers samples, tags them with a 16-bit sequence number and hands {seq, sample} words to the SPI master.
// MBED_RDY rise to SPI_ENA is 4 edges; one burst of up to BURST_LEN words per ready assertion, paced by FIN.
module mbed_tx_framer #(
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 8,
  parameter int TIMEOUT    = 4096,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          SYS_CLK,
  input  logic          RST_N,
  input  logic [15:0]   SAMPLE,
  input  logic          SAMPLE_VALID,
  input  logic          MBED_RDY,
  input  logic          SPI_FIN,
  output logic          SPI_ENA,
  output logic [31:0]   SPI_DATA,
  output logic [LW-1:0] FIFO_LEVEL,
  output logic          BUSY,
  output logic          OVERFLOW,
  output logic          TIMEOUT_ERR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t          state, state_nxt;
  logic            rdy_m, rdy_s;
  logic            fin_q, fin_rise;
  logic [15:0]     seq;
  logic [BW-1:0]   burst_cnt, burst_inc;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;

  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            fifo_full, fifo_empty;
  logic            wr_ok, pop, drop;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign fifo_full  = FIFO_LEVEL == LW'(FIFO_DEPTH);
  assign fifo_empty = FIFO_LEVEL == '0;
  assign pop        = (state == LOAD) && !fifo_empty;
  assign wr_ok      = SAMPLE_VALID && (!fifo_full || pop);
  assign drop       = SAMPLE_VALID && !wr_ok;

  assign fin_rise  = SPI_FIN & ~fin_q;
  assign burst_inc = burst_cnt + BW'(1);
  assign tmo_hit   = tmo_cnt == TW'(TIMEOUT - 1);
  assign BUSY      = state != IDLE;

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_LEVEL <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_ok && !pop)
        FIFO_LEVEL <= FIFO_LEVEL + LW'(1);
      else if (!wr_ok && pop)
        FIFO_LEVEL <= FIFO_LEVEL - LW'(1);
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (wr_ok) mem[wr_ptr] <= SAMPLE;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rdy_s && !fifo_empty) state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: begin
        // A FIN arriving on the last timeout cycle still completes the word.
        if (fin_rise)
          state_nxt = (burst_inc == BW'(BURST_LEN) || fifo_empty) ? DONE : LOAD;
        else if (tmo_hit)
          state_nxt = DONE;
      end
      DONE: if (!rdy_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      rdy_m       <= 1'b0;
      rdy_s       <= 1'b0;
      fin_q       <= 1'b0;
      seq         <= '0;
      burst_cnt   <= '0;
      tmo_cnt     <= '0;
      SPI_ENA     <= 1'b0;
      SPI_DATA    <= '0;
      OVERFLOW    <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state   <= state_nxt;
      rdy_m   <= MBED_RDY;
      rdy_s   <= rdy_m;
      fin_q   <= SPI_FIN;
      SPI_ENA <= state_nxt == SEND;

      if (state == IDLE && state_nxt == LOAD)
        burst_cnt <= '0;
      else if (state == SEND && fin_rise)
        burst_cnt <= burst_inc;

      if (pop) begin
        SPI_DATA <= {seq, mem[rd_ptr]};
        seq      <= seq + 16'd1;
      end

      if (state != SEND)
        tmo_cnt <= '0;
      else if (!tmo_hit)
        tmo_cnt <= tmo_cnt + TW'(1);

      if (drop)
        OVERFLOW <= 1'b1;
      if (state == SEND && !fin_rise && tmo_hit)
        TIMEOUT_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mbed_tx_framer.sv
// Scoreboard bench for mbed_tx_framer: accepted samples are queued at drive time and matched against SPI words.
module tb_mbed_tx_framer;

  logic        SYS_CLK = 1'b0;
  logic        RST_N;
  logic [15:0] SAMPLE;
  logic        SAMPLE_VALID;
  logic        MBED_RDY;
  logic        SPI_FIN;
  logic        SPI_ENA;
  logic [31:0] SPI_DATA;
  logic [4:0]  FIFO_LEVEL;
  logic        BUSY;
  logic        OVERFLOW;
  logic        TIMEOUT_ERR;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb_q[$];
  logic [15:0] exp_seq;
  logic        exp_ovf;

  always #5 SYS_CLK = ~SYS_CLK;

  mbed_tx_framer #(.FIFO_DEPTH(16), .BURST_LEN(8), .TIMEOUT(4096)) dut (
    .SYS_CLK      (SYS_CLK),
    .RST_N        (RST_N),
    .SAMPLE       (SAMPLE),
    .SAMPLE_VALID (SAMPLE_VALID),
    .MBED_RDY     (MBED_RDY),
    .SPI_FIN      (SPI_FIN),
    .SPI_ENA      (SPI_ENA),
    .SPI_DATA     (SPI_DATA),
    .FIFO_LEVEL   (FIFO_LEVEL),
    .BUSY         (BUSY),
    .OVERFLOW     (OVERFLOW),
    .TIMEOUT_ERR  (TIMEOUT_ERR)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N        = 1'b0;
    MBED_RDY     = 1'b0;
    SPI_FIN      = 1'b0;
    SAMPLE_VALID = 1'b0;
    SAMPLE       = '0;
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
    sb_q.delete();
    exp_seq = '0;
    exp_ovf = 1'b0;
  endtask

  task automatic push_sample(input logic [15:0] v);
    SAMPLE       = v;
    SAMPLE_VALID = 1'b1;
    tick();
    SAMPLE_VALID = 1'b0;
    if (sb_q.size() < 16) sb_q.push_back(v);
    else exp_ovf = 1'b1;
  endtask

  task automatic wait_ena(input string tag, output logic seen);
    int n = 0;
    while (!SPI_ENA && n < 40) begin
      tick();
      n++;
    end
    seen = SPI_ENA;
    if (!seen) chk({tag, "_ena_timeout"}, 32'(SPI_ENA), 32'd1);
  endtask

  // Checks the word on the bus against the model, holds it, then completes it with a FIN pulse.
  task automatic serve(input string tag);
    logic        seen;
    logic [31:0] exp_w;
    wait_ena(tag, seen);
    if (!seen) return;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      return;
    end
    exp_w = {exp_seq, sb_q.pop_front()};
    exp_seq++;
    chk({tag, "_data"}, SPI_DATA, exp_w);
    repeat (2) tick();
    chk({tag, "_hold_ena"}, 32'(SPI_ENA), 32'd1);
    chk({tag, "_hold_data"}, SPI_DATA, exp_w);
    SPI_FIN = 1'b1;
    tick();
    SPI_FIN = 1'b0;
    chk({tag, "_ena_drop"}, 32'(SPI_ENA), 32'd0);
  endtask

  task automatic end_burst(input string tag);
    repeat (10) tick();
    chk({tag, "_done_busy"}, 32'(BUSY), 32'd1);
    chk({tag, "_done_ena"}, 32'(SPI_ENA), 32'd0);
    chk({tag, "_level"}, 32'(FIFO_LEVEL), 32'(sb_q.size()));
    MBED_RDY = 1'b0;
    repeat (3) tick();
    chk({tag, "_idle"}, 32'(BUSY), 32'd0);
  endtask

  task automatic burst(input int n, input string tag);
    MBED_RDY = 1'b1;
    repeat (n) serve(tag);
    end_burst(tag);
  endtask

  initial begin
    logic seen;
    logic [31:0] exp_w;

    // Reset values and the basic three-word burst with exact ENA latency.
    do_reset();
    chk("rst_ena", 32'(SPI_ENA), 32'd0);
    chk("rst_data", SPI_DATA, 32'd0);
    chk("rst_level", 32'(FIFO_LEVEL), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_ovf", 32'(OVERFLOW), 32'd0);
    chk("rst_tmo", 32'(TIMEOUT_ERR), 32'd0);
    push_sample(16'h1111);
    push_sample(16'h2222);
    push_sample(16'h3333);
    chk("level3", 32'(FIFO_LEVEL), 32'd3);
    MBED_RDY = 1'b1;
    repeat (3) tick();
    chk("lat_ena_early", 32'(SPI_ENA), 32'd0);
    tick();
    chk("lat_ena", 32'(SPI_ENA), 32'd1);
    chk("lat_data", SPI_DATA, 32'h0000_1111);
    burst(3, "basic");

    // Burst limit: 12 queued, 8 go out, the rest after the next ready.
    do_reset();
    for (int i = 0; i < 12; i++) push_sample(16'h0100 + 16'(i));
    burst(8, "blen_a");
    burst(4, "blen_b");

    // Overflow: the 17th sample is dropped and never sent.
    do_reset();
    for (int i = 0; i < 17; i++) push_sample(16'h0300 + 16'(i));
    chk("ovf_level", 32'(FIFO_LEVEL), 32'd16);
    chk("ovf_flag", 32'(OVERFLOW), 32'(exp_ovf));
    burst(8, "ovf_a");
    burst(8, "ovf_b");

    // Timeout: ENA stays for exactly 4096 cycles, the word is lost, seq moves on.
    push_sample(16'h4444);
    push_sample(16'h5555);
    MBED_RDY = 1'b1;
    wait_ena("tmo", seen);
    if (seen) begin
      exp_w = {exp_seq, sb_q.pop_front()};
      exp_seq++;
      chk("tmo_data", SPI_DATA, exp_w);
      repeat (4095) tick();
      chk("tmo_ena_before", 32'(SPI_ENA), 32'd1);
      chk("tmo_err_before", 32'(TIMEOUT_ERR), 32'd0);
      tick();
      chk("tmo_ena_after", 32'(SPI_ENA), 32'd0);
      chk("tmo_err_after", 32'(TIMEOUT_ERR), 32'd1);
    end
    end_burst("tmo");
    burst(1, "tmo_next");
    chk("tmo_sticky", 32'(TIMEOUT_ERR), 32'd1);

    // Full FIFO, push coinciding with the LOAD pop is accepted.
    do_reset();
    for (int i = 0; i < 16; i++) push_sample(16'h0500 + 16'(i));
    chk("full_level", 32'(FIFO_LEVEL), 32'd16);
    MBED_RDY = 1'b1;
    repeat (3) tick();
    chk("full_load_busy", 32'(BUSY), 32'd1);
    chk("full_load_ena", 32'(SPI_ENA), 32'd0);
    SAMPLE       = 16'hABCD;
    SAMPLE_VALID = 1'b1;
    tick();
    SAMPLE_VALID = 1'b0;
    sb_q.push_back(16'hABCD);
    chk("full_pp_level", 32'(FIFO_LEVEL), 32'd16);
    chk("full_pp_ovf", 32'(OVERFLOW), 32'd0);
    chk("full_pp_ena", 32'(SPI_ENA), 32'd1);
    burst(8, "full_a");
    burst(8, "full_b");
    burst(1, "full_c");
    chk("full_ovf_end", 32'(OVERFLOW), 32'd0);

    // Sequence wrap 0xFFFF -> 0x0000.
    do_reset();
    push_sample(16'h6001);
    push_sample(16'h6002);
    force dut.seq = 16'hFFFF;
    tick();
    release dut.seq;
    exp_seq = 16'hFFFF;
    burst(2, "wrap");

    // Asynchronous reset in the middle of SEND.
    do_reset();
    push_sample(16'h7001);
    push_sample(16'h7002);
    push_sample(16'h7003);
    MBED_RDY = 1'b1;
    wait_ena("arst", seen);
    #3;
    RST_N = 1'b0;
    #1;
    chk("arst_ena", 32'(SPI_ENA), 32'd0);
    chk("arst_level", 32'(FIFO_LEVEL), 32'd0);
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_data", SPI_DATA, 32'd0);
    tick();
    RST_N = 1'b1;
    sb_q.delete();
    exp_seq = '0;
    tick();
    push_sample(16'h7777);
    burst(1, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mbed_tx_framer.md
# mbed_tx_framer

Upstream feeder for the MBED SPI master. Buffers 16-bit samples from the acquisition logic in a small FIFO, tags each with a 16-bit sequence number, and hands 32-bit words `{SEQ, SAMPLE}` to the SPI master one at a time. It gates `ENA` and consumes the master's `FIN` completion pulse. Bursts are paced by the MBED's ready line.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: sample FIFO entries; power of two, at least 4.
- `BURST_LEN`, 8: maximum words sent per MBED ready request.
- `TIMEOUT`, 4096: `SYS_CLK` cycles allowed in SEND before abort.

Ports:
- `SYS_CLK`, in, 1: single clock (40 MHz domain). All logic is on rising edge.
- `RST_N`, in, 1: reset. Asynchronous, active-low. Applied asynchronously; removal is synchronous to `SYS_CLK`.
- `SAMPLE`, in, 16: sample data. Captured when `SAMPLE_VALID`=1.
- `SAMPLE_VALID`, in, 1: single-cycle write strobe.
- `MBED_RDY`, in, 1: MBED ready line. Asynchronous; synchronized internally.
- `SPI_FIN`, in, 1: FIN from the SPI master, same clock domain. A rising edge marks word complete.
- `SPI_ENA`, out, 1: enable to the SPI master. Registered.
- `SPI_DATA`, out, 32: `{seq[15:0], sample[15:0]}`. Registered.
- `FIFO_LEVEL`, out, log2(`FIFO_DEPTH`)+1: current occupancy.
- `BUSY`, out, 1: high whenever the state is not IDLE.
- `OVERFLOW`, out, 1: sticky; a sample was dropped.
- `TIMEOUT_ERR`, out, 1: sticky; a word was aborted.

## Operation
- Reset values: `SPI_ENA`=0, `SPI_DATA`=0, `FIFO_LEVEL`=0, `BUSY`=0, `OVERFLOW`=0, `TIMEOUT_ERR`=0. Internally, seq=0, burst count=0, state IDLE, FIFO empty, and the sync and edge registers are 0.
- `MBED_RDY` passes through a two-flop synchronizer to give `rdy_s`.
- `SPI_FIN` is registered once; `fin_rise` = `SPI_FIN` & ~`fin_q`.
- FIFO write occurs when `SAMPLE_VALID` is high and the FIFO is not full.
  - Exception: when full and a pop (LOAD) happens in the same cycle, the write is accepted and the level is unchanged.
  - Otherwise a write to a full FIFO drops the sample and sets `OVERFLOW`.
- The FIFO pop occurs only in LOAD. A simultaneous push and pop leaves `FIFO_LEVEL` unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- FSM:
  - IDLE → LOAD when `rdy_s`=1 and FIFO is not empty. Clear the burst count. If `rdy_s`=1 and FIFO is empty, stay in IDLE.
  - LOAD (1 cycle): pop the head. `SPI_DATA` <= {seq, head}; seq <= seq+1, wrapping 0xFFFF→0x0000. Go to SEND.
  - SEND: `SPI_ENA`=1 and `SPI_DATA` is held. On `fin_rise`, increment the burst count and deassert `SPI_ENA`.
    - Go to DONE if burst count = `BURST_LEN` or the FIFO is empty.
    - Otherwise go to LOAD.
  - Timeout in SEND: a timeout counter is cleared on SEND entry. If it reaches `TIMEOUT`-1 without `fin_rise`, drop `SPI_ENA`, set `TIMEOUT_ERR`, and go to DONE. The word is lost and seq is not rewound.
  - DONE: `SPI_ENA`=0. Go to IDLE when `rdy_s`=0. This gives one burst per ready assertion.
- A `fin_rise` outside SEND is ignored.
- Asserting `RST_N` mid-burst forces every output and internal register to its reset value immediately. FIFO contents are discarded.
- Sticky flags clear only on reset.

## Timing
- `MBED_RDY` rising is sampled at edge n; `rdy_s` is high after edge n+1.
- The state is LOAD after edge n+2. `SPI_ENA`=1 with valid `SPI_DATA` after edge n+3. Input-to-ENA latency is 4 edges.
- `SPI_DATA` changes only at the edge that leaves LOAD. It is stable for the whole of SEND.
- `SPI_FIN` goes high during cycle k, so `fin_rise` is seen in cycle k. `SPI_ENA`=0 after edge k+1, with the state LOAD or DONE. ENA is low for at least 1 cycle between words.
- `FIFO_LEVEL` updates at the edge after the push or pop.
- Timeout fires exactly `TIMEOUT` cycles after SEND entry.

## Test plan
- Reset, then push 3 samples 0x1111/0x2222/0x3333, then raise `MBED_RDY`:
  - `SPI_ENA` rises 4 edges later with `SPI_DATA`=0x00001111.
  - After each `FIN` pulse the next words are 0x00012222 and 0x00023333.
  - Then DONE, and IDLE once RDY drops.
- Push 12 samples, with `BURST_LEN`=8, and hold RDY high:
  - Exactly 8 words are sent and the block stays in DONE.
  - Lowering and re-raising RDY sends the remaining 4, with seq 8..11.
- Write 17 samples with no RDY: `FIFO_LEVEL`=16 and `OVERFLOW`=1. The 17th sample is never transmitted.
- Start SEND and never pulse `FIN`:
  - After 4096 cycles `SPI_ENA`=0 and `TIMEOUT_ERR`=1.
  - The next burst uses seq+1.
- FIFO full while a LOAD pops and `SAMPLE_VALID` is high in the same cycle: the write is accepted, `FIFO_LEVEL` stays 16, and `OVERFLOW` stays 0.
- Preload seq to 0xFFFF via 65535 sends (or force): the next two words carry seq 0xFFFF then 0x0000.
- Pulse `RST_N` low mid-SEND: `SPI_ENA` drops asynchronously, `FIFO_LEVEL`=0, and the first post-reset word uses seq 0.
